// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative 32x32 multiply / 32/32 divide unit for the EX stage.
// Handles MULT/MULTU/DIV/DIVU in 33 cycles (32 radix-2 steps plus one
// sign-fix/write cycle). It owns the HI/LO registers, including MTHI/MTLO
// writes, and produces the pipeline stall.
module ex_muldiv (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        flush,
    input  logic        hilo_we,
    input  logic        hilo_sel,
    input  logic [31:0] hilo_wdata,
    output logic        stall,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    // Request captured at accept. The operands themselves live in acc/opnd.
    typedef struct packed {
        logic [1:0] op;
        logic       neg_a;   // rs was negative (signed ops only)
        logic       neg_b;   // rt was negative (signed ops only)
    } req_t;

    state_t      state;
    req_t        req;
    logic [5:0]  cnt;
    logic [63:0] acc;        // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
    logic [31:0] opnd;       // mul: multiplicand; div: divisor

    logic        accept;
    logic        is_signed;
    logic [31:0] rs_mag;
    logic [31:0] rt_mag;
    logic        fix_wr;

    logic [32:0] mul_sum;
    logic [32:0] div_trial;
    logic        div_ge;
    logic [31:0] div_rem;
    logic [63:0] step_acc;

    logic        res_neg;
    logic [63:0] prod;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    assign busy      = (state != IDLE);
    assign stall     = busy | (start & ~done & ~flush);
    // A done pulse blocks re-acceptance, so the held instruction can leave EX.
    assign accept    = start & (state == IDLE) & ~done & ~flush;
    assign is_signed = ~op[0];
    assign rs_mag    = (is_signed & rs_data[31]) ? (32'd0 - rs_data) : rs_data;
    assign rt_mag    = (is_signed & rt_data[31]) ? (32'd0 - rt_data) : rt_data;
    assign fix_wr    = (state == FIX) & ~flush;

    // One radix-2 step. The multiply adds and shifts right. The divide shifts left
    // and subtracts when the trial remainder covers the divisor. The remainder is
    // below 2*divisor, so the 32-bit difference never truncates.
    always_comb begin
        mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
        div_trial = acc[63:31];
        div_ge    = (div_trial >= {1'b0, opnd});
        div_rem   = div_trial[31:0] - opnd;
        step_acc  = {mul_sum, acc[31:1]};
        if (req.op[1]) begin
            if (div_ge)
                step_acc = {div_rem, acc[30:0], 1'b1};
            else
                step_acc = {div_trial[31:0], acc[30:0], 1'b0};
        end
    end

    // Sign fix and result selection for the FIX write.
    // A zero divisor gives an all-ones quotient and a remainder equal to |rs|.
    // Restoring the sign of rs therefore returns hi = rs_data directly.
    always_comb begin
        res_neg = req.neg_a ^ req.neg_b;
        prod    = res_neg ? (64'd0 - acc) : acc;
        quo     = res_neg ? (32'd0 - acc[31:0]) : acc[31:0];
        rem     = req.neg_a ? (32'd0 - acc[63:32]) : acc[63:32];
        res_hi  = prod[63:32];
        res_lo  = prod[31:0];
        if (req.op[1]) begin
            res_hi = rem;
            res_lo = (opnd == 32'd0) ? 32'hFFFF_FFFF : quo;
        end
    end

    // Control FSM plus working registers; done is registered off FIX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            req   <= '0;
            cnt   <= 6'd0;
            acc   <= 64'd0;
            opnd  <= 32'd0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        req.op    <= op;
                        req.neg_a <= is_signed & rs_data[31];
                        req.neg_b <= is_signed & rt_data[31];
                        opnd      <= op[1] ? rt_mag : rs_mag;
                        acc       <= {32'd0, (op[1] ? rs_mag : rt_mag)};
                        cnt       <= 6'd32;
                        state     <= CALC;
                    end
                end
                CALC: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        acc <= step_acc;
                        cnt <= cnt - 6'd1;
                        if (cnt == 6'd1)
                            state <= FIX;
                    end
                end
                FIX: begin
                    state <= IDLE;
                    if (!flush)
                        done <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // HI/LO change only on a FIX write or an MTHI/MTLO accepted in IDLE.
    // A write that coincides with an accept lands first. The result overwrites it later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end else if (fix_wr) begin
            hi <= res_hi;
            lo <= res_lo;
        end else if (hilo_we && (state == IDLE)) begin
            if (hilo_sel)
                hi <= hilo_wdata;
            else
                lo <= hilo_wdata;
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: arithmetic vectors, latency, flush, start
// held high, MTHI/MTLO interactions and asynchronous reset.
module tb_ex_muldiv;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        flush;
    logic        hilo_we;
    logic        hilo_sel;
    logic [31:0] hilo_wdata;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;

    ex_muldiv dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .op         (op),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .flush      (flush),
        .hilo_we    (hilo_we),
        .hilo_sel   (hilo_sel),
        .hilo_wdata (hilo_wdata),
        .stall      (stall),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    // MTHI (sel=1) / MTLO (sel=0) issued in IDLE.
    task automatic mt(input logic sel, input logic [31:0] d);
        @(posedge clk); #1;
        hilo_we = 1'b1; hilo_sel = sel; hilo_wdata = d;
        @(posedge clk); #1;
        hilo_we = 1'b0;
    endtask

    // Issue one operation, count busy cycles, then check the done pulse and the result.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        int nb;
        int early;
        nb = 0; early = 0;
        @(posedge clk); #1;
        start = 1'b1; op = o; rs_data = a; rt_data = b;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) break;
            nb++;
            if (done) early = 1;
        end
        chk({tag, " busy_cycles"}, 64'(nb), 64'd33);
        chk({tag, " done_early"}, 64'(early), 64'd0);
        chk({tag, " done"}, {63'd0, done}, 64'd1);
        chk({tag, " hilo"}, {hi, lo}, {ehi, elo});
        @(negedge clk);
        chk({tag, " done_1cyc"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        int seen;
        rst_n = 1'b0; start = 1'b0; op = 2'd0; rs_data = 32'd0; rt_data = 32'd0;
        flush = 1'b0; hilo_we = 1'b0; hilo_sel = 1'b0; hilo_wdata = 32'd0;

        // Reset state, including stall following start during reset.
        #2;
        chk("rst busy", {63'd0, busy}, 64'd0);
        chk("rst done", {63'd0, done}, 64'd0);
        chk("rst stall", {63'd0, stall}, 64'd0);
        chk("rst hilo", {hi, lo}, 64'd0);
        start = 1'b1;
        #1;
        chk("rst stall_start", {63'd0, stall}, 64'd1);
        start = 1'b0;
        #9 rst_n = 1'b1;

        // Arithmetic vectors.
        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult_neg",  2'b00, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("mult_min",  2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        run_op("div_neg",   2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu_zero", 2'b11, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF);
        run_op("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        run_op("div_zero",  2'b10, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF);
        run_op("divu_gen",  2'b11, 32'hFFFF_FFFF, 32'h10,        32'h0000_000F, 32'h0FFF_FFFF);

        // Flush on CALC cycle 10: operation dropped, HI/LO untouched, no done.
        mt(1'b1, 32'h1234_5678);
        mt(1'b0, 32'h1234_5678);
        chk("mt hilo", {hi, lo}, {32'h1234_5678, 32'h1234_5678});
        @(posedge clk); #1;
        start = 1'b1; op = 2'b11; rs_data = 32'd1000; rt_data = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("flush pre_busy", {63'd0, busy}, 64'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush busy", {63'd0, busy}, 64'd0);
        chk("flush hilo", {hi, lo}, {32'h1234_5678, 32'h1234_5678});
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) seen = 1;
        end
        chk("flush no_done", 64'(seen), 64'd0);

        // Start held high, with MTHI coinciding with the accept and MTLO while busy.
        @(posedge clk); #1;
        start = 1'b1; op = 2'b01; rs_data = 32'd3; rt_data = 32'd5;
        hilo_we = 1'b1; hilo_sel = 1'b1; hilo_wdata = 32'hCAFE_BABE;
        @(posedge clk); #1;
        hilo_we = 1'b0;
        @(negedge clk);
        chk("hold busy", {63'd0, busy}, 64'd1);
        chk("hold mthi_at_accept", {32'd0, hi}, {32'd0, 32'hCAFE_BABE});
        @(posedge clk); #1;
        hilo_we = 1'b1; hilo_sel = 1'b0; hilo_wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        hilo_we = 1'b0;
        @(negedge clk);
        chk("hold mtlo_busy", {32'd0, lo}, {32'd0, 32'h1234_5678});
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                chk("hold stall_done", {63'd0, stall}, 64'd0);
                break;
            end
        end
        chk("hold done_seen", 64'(seen), 64'd1);
        chk("hold hilo", {hi, lo}, {32'd0, 32'd15});
        @(negedge clk);
        chk("hold no_restart", {62'd0, busy, done}, 64'd0);
        chk("hold stall_again", {63'd0, stall}, 64'd1);
        start = 1'b0;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (done || busy) seen = 1;
        end
        chk("hold quiet", 64'(seen), 64'd0);

        // Asynchronous reset mid-CALC.
        mt(1'b1, 32'h55AA_55AA);
        @(posedge clk); #1;
        start = 1'b1; op = 2'b00; rs_data = 32'd5; rt_data = 32'd6;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        chk("rstmid pre_busy", {63'd0, busy}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rstmid busy", {63'd0, busy}, 64'd0);
        chk("rstmid hilo", {hi, lo}, 64'd0);
        chk("rstmid stall", {63'd0, stall}, 64'd0);
        #3 rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) seen = 1;
        end
        chk("rstmid no_done", 64'(seen), 64'd0);
        chk("rstmid hilo_after", {hi, lo}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
